// File: rtl/rv_alu_issue.sv
`default_nettype none
// ============================================================================
//  Module   : rv_alu_issue
//  Purpose  : ALU issue stage. Accepts a register-read stage instruction
//             (instruction word, PC, rs1/rs2 data) over a valid/ready
//             handshake, decodes RV32I integer ops into operand A, operand B
//             and a one-hot op select, and presents them from registered
//             outputs over a valid/ready handshake to the execute stage.
//  Options  : RV_ISSUE_SKID_EN - 2-entry skid buffer with a registered
//             in_ready_o. Undefined: single output register with a
//             combinational ready path.
//  Revision : 1.0 - initial release
// ============================================================================
module rv_alu_issue #(
    parameter int XLEN    = 32,
    parameter int OPSEL_W = 10
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [31:0]        instr_i,
    input  logic [XLEN-1:0]    pc_i,
    input  logic [XLEN-1:0]    rs1_data_i,
    input  logic [XLEN-1:0]    rs2_data_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [XLEN-1:0]    opr_a_o,
    output logic [XLEN-1:0]    opr_b_o,
    output logic [OPSEL_W-1:0] op_sel_o,
    output logic               illegal_o,
    output logic [31:0]        issue_cnt_o
);

    // Opcodes
    localparam logic [6:0] C_OPC_OP     = 7'b0110011;
    localparam logic [6:0] C_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] C_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] C_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] C_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] C_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] C_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] C_OPC_JALR   = 7'b1100111;

    // Bit positions inside the one-hot op select
    localparam logic [3:0] C_IDX_ADD  = 4'd0;
    localparam logic [3:0] C_IDX_SUB  = 4'd1;
    localparam logic [3:0] C_IDX_SLL  = 4'd2;
    localparam logic [3:0] C_IDX_SRL  = 4'd3;
    localparam logic [3:0] C_IDX_SRA  = 4'd4;
    localparam logic [3:0] C_IDX_OR   = 4'd5;
    localparam logic [3:0] C_IDX_AND  = 4'd6;
    localparam logic [3:0] C_IDX_XOR  = 4'd7;
    localparam logic [3:0] C_IDX_SLTU = 4'd8;
    localparam logic [3:0] C_IDX_SLT  = 4'd9;

    localparam logic [6:0] C_F7_BASE = 7'b0000000;
    localparam logic [6:0] C_F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [XLEN-1:0]    a;
        logic [XLEN-1:0]    b;
        logic [OPSEL_W-1:0] sel;
        logic               ill;
    } entry_t;

    // funct3 -> ALU op; alt selects SUB/SRA in place of ADD/SRL
    function automatic logic [3:0] f3_idx(input logic [2:0] f3, input logic alt);
        logic [3:0] idx;
        case (f3)
            3'b000:  idx = alt ? C_IDX_SUB : C_IDX_ADD;
            3'b001:  idx = C_IDX_SLL;
            3'b010:  idx = C_IDX_SLT;
            3'b011:  idx = C_IDX_SLTU;
            3'b100:  idx = C_IDX_XOR;
            3'b101:  idx = alt ? C_IDX_SRA : C_IDX_SRL;
            3'b110:  idx = C_IDX_OR;
            default: idx = C_IDX_AND;
        endcase
        return idx;
    endfunction

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] shamt;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];
    assign imm_i  = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
    assign imm_s  = {{(XLEN-12){instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_u  = {instr_i[31:12], 12'h000};
    assign shamt  = {{(XLEN-5){1'b0}}, instr_i[24:20]};

    logic            dec_legal;
    logic [3:0]      dec_idx;
    logic [XLEN-1:0] dec_a;
    logic [XLEN-1:0] dec_b;
    entry_t          dec;

    // Decode the incoming instruction into an issue entry
    always_comb begin
        dec_legal = 1'b0;
        dec_idx   = C_IDX_ADD;
        dec_a     = '0;
        dec_b     = '0;
        case (opcode)
            C_OPC_OP: begin
                dec_a = rs1_data_i;
                dec_b = rs2_data_i;
                if (funct7 == C_F7_BASE) begin
                    dec_legal = 1'b1;
                    dec_idx   = f3_idx(funct3, 1'b0);
                end else if (funct7 == C_F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
                    dec_legal = 1'b1;
                    dec_idx   = f3_idx(funct3, 1'b1);
                end
            end
            C_OPC_OP_IMM: begin
                dec_a = rs1_data_i;
                dec_b = imm_i;
                if (funct3 == 3'b001) begin
                    dec_b     = shamt;
                    dec_legal = (funct7 == C_F7_BASE);
                    dec_idx   = C_IDX_SLL;
                end else if (funct3 == 3'b101) begin
                    dec_b     = shamt;
                    dec_legal = (funct7 == C_F7_BASE) || (funct7 == C_F7_ALT);
                    dec_idx   = (funct7 == C_F7_ALT) ? C_IDX_SRA : C_IDX_SRL;
                end else begin
                    // SLTI/SLTIU/ADDI/XORI/ORI/ANDI: upper bits are immediate
                    dec_legal = 1'b1;
                    dec_idx   = f3_idx(funct3, 1'b0);
                end
            end
            C_OPC_LOAD: begin
                dec_a     = rs1_data_i;
                dec_b     = imm_i;
                dec_legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
            end
            C_OPC_STORE: begin
                dec_a     = rs1_data_i;
                dec_b     = imm_s;
                dec_legal = (funct3[2] == 1'b0) && (funct3 != 3'b011);
            end
            C_OPC_LUI: begin
                dec_b     = imm_u;
                dec_legal = 1'b1;
            end
            C_OPC_AUIPC: begin
                dec_a     = pc_i;
                dec_b     = imm_u;
                dec_legal = 1'b1;
            end
            C_OPC_JAL: begin
                dec_a     = pc_i;
                dec_b     = XLEN'(4);
                dec_legal = 1'b1;
            end
            C_OPC_JALR: begin
                dec_a     = pc_i;
                dec_b     = XLEN'(4);
                dec_legal = (funct3 == 3'b000);
            end
            default: begin
                dec_legal = 1'b0;
            end
        endcase

        // Illegal entries carry zero operands and no op bit
        dec = '0;
        if (dec_legal) begin
            dec.a   = dec_a;
            dec.b   = dec_b;
            dec.sel = OPSEL_W'(1) << dec_idx;
        end else begin
            dec.ill = 1'b1;
        end
    end

    logic        in_xfer;
    logic        out_xfer;
    logic [31:0] cnt_q;
    logic [31:0] cnt_d;
    entry_t      head;

`ifdef RV_ISSUE_SKID_EN
    entry_t [1:0] ent_q;
    entry_t [1:0] ent_d;
    logic [1:0]   fill_q;
    logic [1:0]   fill_d;
    logic [1:0]   wr_idx;
    logic         ready_q;
    logic         ready_d;

    assign head        = ent_q[0];
    assign out_valid_o = (fill_q != 2'd0);
    assign in_ready_o  = ready_q;
    assign out_xfer    = out_valid_o && out_ready_i;
    assign in_xfer     = in_valid_i && ready_q;
    assign wr_idx      = fill_q - {1'b0, out_xfer};

    // FIFO update: pop shifts entry 1 to the head, push lands behind survivors
    always_comb begin
        ent_d  = ent_q;
        fill_d = fill_q + {1'b0, in_xfer} - {1'b0, out_xfer};
        if (out_xfer) begin
            ent_d[0] = ent_q[1];
        end
        if (in_xfer) begin
            if (wr_idx == 2'd0) begin
                ent_d[0] = dec;
            end else begin
                ent_d[1] = dec;
            end
        end
        if (flush_i) begin
            fill_d = 2'd0;
        end
        ready_d = (fill_d != 2'd2);
    end

    // Skid buffer storage and registered ready
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ent_q   <= '0;
            fill_q  <= 2'd0;
            ready_q <= 1'b0;
        end else begin
            ent_q   <= ent_d;
            fill_q  <= fill_d;
            ready_q <= ready_d;
        end
    end
`else
    entry_t ent_q;
    entry_t ent_d;
    logic   valid_q;
    logic   valid_d;
    logic   rdy_en_q;

    assign head        = ent_q;
    assign out_valid_o = valid_q;
    // rdy_en_q keeps ready low during reset and for the first edge after it
    assign in_ready_o  = rdy_en_q && (!valid_q || out_ready_i);
    assign out_xfer    = valid_q && out_ready_i;
    assign in_xfer     = in_valid_i && in_ready_o;

    // Single output register: flush wins, then load, then drain
    always_comb begin
        valid_d = valid_q;
        ent_d   = ent_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (in_xfer) begin
            valid_d = 1'b1;
            ent_d   = dec;
        end else if (out_xfer) begin
            valid_d = 1'b0;
        end
    end

    // Output register and ready enable
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ent_q    <= '0;
            valid_q  <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            ent_q    <= ent_d;
            valid_q  <= valid_d;
            rdy_en_q <= 1'b1;
        end
    end
`endif

    assign opr_a_o     = head.a;
    assign opr_b_o     = head.b;
    assign op_sel_o    = head.sel;
    assign illegal_o   = head.ill;
    assign issue_cnt_o = cnt_q;

    // Transfer counter counts every output handshake, flush or not
    always_comb begin
        cnt_d = cnt_q + {31'd0, out_xfer};
    end

    // Transfer counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rv_alu_issue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rv_alu_issue
//  Purpose  : Self-checking bench for rv_alu_issue: decode vector table,
//             backpressure/flush/reset sequences and randomized traffic
//             checked against a transaction-level queue model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rv_alu_issue;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] instr_i;
    logic [31:0] pc_i;
    logic [31:0] rs1_data_i;
    logic [31:0] rs2_data_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] opr_a_o;
    logic [31:0] opr_b_o;
    logic [9:0]  op_sel_o;
    logic        illegal_o;
    logic [31:0] issue_cnt_o;

    always #5 clk_i = ~clk_i;

    rv_alu_issue #(.XLEN(32), .OPSEL_W(10)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .instr_i     (instr_i),
        .pc_i        (pc_i),
        .rs1_data_i  (rs1_data_i),
        .rs2_data_i  (rs2_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .opr_a_o     (opr_a_o),
        .opr_b_o     (opr_b_o),
        .op_sel_o    (op_sel_o),
        .illegal_o   (illegal_o),
        .issue_cnt_o (issue_cnt_o)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [9:0]  sel;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] a;
        logic [31:0] b;
        logic [9:0]  sel;
        logic        ill;
    } vec_t;

    exp_t        q[$];
    int unsigned m_cnt = 0;
    bit          m_rdy = 0;
    bit          last_in_x = 0;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference decode from the ISA rules; idx = position of the op bit
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                        input logic [31:0] r1, input logic [31:0] r2);
        exp_t e;
        int   idx;
        int   f3;
        int   alu_of_f3[8] = '{0, 2, 9, 8, 7, 3, 5, 6};
        logic [6:0]  f7;
        logic [11:0] s12;
        f3  = int'(ins[14:12]);
        f7  = ins[31:25];
        s12 = {ins[31:25], ins[11:7]};
        idx = -1;
        e.a = 32'd0;
        e.b = 32'd0;
        case (ins[6:0])
            7'h33: begin
                e.a = r1; e.b = r2;
                if (f7 == 7'h00) idx = alu_of_f3[f3];
                else if (f7 == 7'h20 && f3 == 0) idx = 1;
                else if (f7 == 7'h20 && f3 == 5) idx = 4;
            end
            7'h13: begin
                e.a = r1; e.b = 32'($signed(ins[31:20]));
                if (f3 == 1) begin
                    e.b = 32'(ins[24:20]);
                    if (f7 == 7'h00) idx = 2;
                end else if (f3 == 5) begin
                    e.b = 32'(ins[24:20]);
                    if (f7 == 7'h00) idx = 3;
                    else if (f7 == 7'h20) idx = 4;
                end else begin
                    idx = alu_of_f3[f3];
                end
            end
            7'h03: begin
                e.a = r1; e.b = 32'($signed(ins[31:20]));
                if (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) idx = 0;
            end
            7'h23: begin
                e.a = r1; e.b = 32'($signed(s12));
                if (f3 <= 2) idx = 0;
            end
            7'h37: begin e.a = 0;  e.b = ins & 32'hFFFFF000; idx = 0; end
            7'h17: begin e.a = pc; e.b = ins & 32'hFFFFF000; idx = 0; end
            7'h6F: begin e.a = pc; e.b = 4; idx = 0; end
            7'h67: begin e.a = pc; e.b = 4; if (f3 == 0) idx = 0; end
            default: ;
        endcase
        if (idx < 0) begin
            e.a = 0; e.b = 0; e.sel = 10'd0; e.ill = 1'b1;
        end else begin
            e.sel = 10'(1 << idx); e.ill = 1'b0;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 11))
            0, 1:    w[6:0] = 7'h33;
            2, 3:    w[6:0] = 7'h13;
            4:       w[6:0] = 7'h03;
            5:       w[6:0] = 7'h23;
            6:       w[6:0] = 7'h37;
            7:       w[6:0] = 7'h17;
            8:       w[6:0] = 7'h6F;
            9:       w[6:0] = 7'h67;
            10:      w[6:0] = 7'h63;
            default: ;
        endcase
        if (w[6:0] == 7'h33 || w[6:0] == 7'h13) begin
            case ($urandom_range(0, 3))
                0, 1:    w[31:25] = 7'h00;
                2:       w[31:25] = 7'h20;
                default: ;
            endcase
        end
        return w;
    endfunction

    // At a negedge: compare DUT to the model, then apply the coming edge to it
    task automatic model_check();
        bit exp_ready;
        chk("out_valid", out_valid_o, q.size() != 0);
        if (q.size() != 0) begin
            chk("opr_a", opr_a_o, q[0].a);
            chk("opr_b", opr_b_o, q[0].b);
            chk("op_sel", op_sel_o, q[0].sel);
            chk("illegal", illegal_o, q[0].ill);
        end
        chk("issue_cnt", issue_cnt_o, m_cnt);
`ifdef RV_ISSUE_SKID_EN
        exp_ready = m_rdy && (q.size() < 2);
`else
        exp_ready = m_rdy && (q.size() == 0 || out_ready_i);
`endif
        chk("in_ready", in_ready_o, exp_ready);
        last_in_x = in_valid_i && exp_ready;
        if (q.size() != 0 && out_ready_i) begin
            void'(q.pop_front());
            m_cnt++;
        end
        if (flush_i) q.delete();
        else if (last_in_x) q.push_back(ref_decode(instr_i, pc_i, rs1_data_i, rs2_data_i));
        m_rdy = 1;
    endtask

    task automatic step();
        @(negedge clk_i);
        model_check();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] r1, input logic [31:0] r2);
        in_valid_i = 1'b1; instr_i = ins; pc_i = pc; rs1_data_i = r1; rs2_data_i = r2;
    endtask

    // Ready probe with the stage full: base ready follows out_ready, skid does not
    task automatic probe_ready();
        @(negedge clk_i);
        out_ready_i = 1'b0; #1;
        chk("ready_stall", in_ready_o, 1'b0);
        out_ready_i = 1'b1; #1;
`ifdef RV_ISSUE_SKID_EN
        chk("ready_state_only", in_ready_o, 1'b0);
`else
        chk("ready_comb", in_ready_o, 1'b1);
`endif
        out_ready_i = 1'b0; #1;
        model_check();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, out_valid_o, 0);
        chk({tag, "_ready"}, in_ready_o, 0);
        chk({tag, "_a"}, opr_a_o, 0);
        chk({tag, "_b"}, opr_b_o, 0);
        chk({tag, "_sel"}, op_sel_o, 0);
        chk({tag, "_ill"}, illegal_o, 0);
        chk({tag, "_cnt"}, issue_cnt_o, 0);
    endtask

    initial begin
        vec_t tbl[$];
        int   k;
        int   unsigned cnt0;

        rst_ni = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
        instr_i = 0; pc_i = 0; rs1_data_i = 0; rs2_data_i = 0;

        tbl.push_back('{32'h002081B3, 32'h0, 32'd5, 32'd7, 32'd5, 32'd7, 10'h001, 1'b0});
        tbl.push_back('{32'hFFF00093, 32'h0, 32'd0, 32'd9, 32'd0, 32'hFFFFFFFF, 10'h001, 1'b0});
        tbl.push_back('{32'h40208033, 32'h0, 32'd10, 32'd3, 32'd10, 32'd3, 10'h002, 1'b0});
        tbl.push_back('{32'h4030D093, 32'h0, 32'h80000000, 32'd1, 32'h80000000, 32'd3, 10'h010, 1'b0});
        tbl.push_back('{32'h123450B7, 32'h0, 32'h55, 32'h66, 32'd0, 32'h12345000, 10'h001, 1'b0});
        tbl.push_back('{32'h00208063, 32'h40, 32'd1, 32'd2, 32'd0, 32'd0, 10'h000, 1'b1});
        tbl.push_back('{32'hFE20D0B3, 32'h0, 32'd1, 32'd2, 32'd0, 32'd0, 10'h000, 1'b1});
        tbl.push_back('{32'h00001097, 32'h100, 32'd1, 32'd2, 32'h100, 32'h1000, 10'h001, 1'b0});
        tbl.push_back('{32'h008000EF, 32'h200, 32'd1, 32'd2, 32'h200, 32'd4, 10'h001, 1'b0});
        tbl.push_back('{32'h003130B3, 32'h0, 32'd11, 32'd12, 32'd11, 32'd12, 10'h100, 1'b0});
        tbl.push_back('{32'hFE20AE23, 32'h0, 32'h1000, 32'd2, 32'h1000, 32'hFFFFFFFC, 10'h001, 1'b0});
        tbl.push_back('{32'h40109093, 32'h0, 32'd1, 32'd2, 32'd0, 32'd0, 10'h000, 1'b1});
        tbl.push_back('{32'h0F00F093, 32'h0, 32'hABCD, 32'd2, 32'hABCD, 32'hF0, 10'h040, 1'b0});
        tbl.push_back('{32'h003120B3, 32'h0, 32'd3, 32'd4, 32'd3, 32'd4, 10'h200, 1'b0});
        tbl.push_back('{32'h00000073, 32'h0, 32'd3, 32'd4, 32'd0, 32'd0, 10'h000, 1'b1});

        // Reset state
        #12;
        check_all_zero("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        chk("ready_before_edge", in_ready_o, 1'b0);
        @(posedge clk_i); #1;
        chk("ready_after_edge", in_ready_o, 1'b1);
        m_rdy = 1;

        // Decode table, one per cycle at full throughput
        foreach (tbl[i]) begin
            drive(tbl[i].instr, tbl[i].pc, tbl[i].rs1, tbl[i].rs2);
            step();
            chk("tbl_valid", out_valid_o, 1'b1);
            chk("tbl_a", opr_a_o, tbl[i].a);
            chk("tbl_b", opr_b_o, tbl[i].b);
            chk("tbl_sel", op_sel_o, tbl[i].sel);
            chk("tbl_ill", illegal_o, tbl[i].ill);
        end
        in_valid_i = 1'b0;
        step();
        step();

        // Backpressure: three inputs queued against a 3-cycle stall
        cnt0 = m_cnt;
        k = 0;
        out_ready_i = 1'b0;
        for (int cyc = 0; cyc < 12 && (k < 3 || q.size() != 0); cyc++) begin
            if (k < 3) drive(32'h002081B3, 32'h0, 32'(100 + k), 32'(200 + k));
            else in_valid_i = 1'b0;
            out_ready_i = (cyc >= 3);
            if (cyc == 2) begin
                probe_ready();
            end else begin
                step();
            end
            if (last_in_x) k++;
        end
        in_valid_i = 1'b0;
        chk("bp_all_sent", k, 3);
        chk("bp_drained", q.size(), 0);
        step();
        chk("bp_cnt", issue_cnt_o, cnt0 + 3);

        // Flush with an entry held and a new input presented
        out_ready_i = 1'b0;
        drive(32'h00B00093, 32'h0, 32'd1, 32'd1);
        step();
        cnt0 = m_cnt;
        drive(32'h002081B3, 32'h0, 32'd9, 32'd9);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0; in_valid_i = 1'b0;
        chk("flush_valid", out_valid_o, 1'b0);
        chk("flush_cnt", issue_cnt_o, cnt0);
        step();

        // Flush coinciding with an output transfer still counts it
        drive(32'h00B00093, 32'h0, 32'd2, 32'd2);
        step();
        cnt0 = m_cnt;
        out_ready_i = 1'b1; flush_i = 1'b1; in_valid_i = 1'b0;
        step();
        flush_i = 1'b0;
        chk("flush_xfer_valid", out_valid_o, 1'b0);
        chk("flush_xfer_cnt", issue_cnt_o, cnt0 + 1);
        step();

        // Randomized traffic, async reset mid-stream, more traffic, drain
        for (int n = 0; n < 500; n++) begin
            if (n == 300) begin
                in_valid_i = 1'b1; out_ready_i = 1'b0; flush_i = 1'b0;
                step();
                step();
                #2 rst_ni = 1'b0;
                #1;
                check_all_zero("async_rst");
                q.delete(); m_cnt = 0; m_rdy = 0;
                in_valid_i = 1'b0;
                @(negedge clk_i);
                rst_ni = 1'b1;
                @(posedge clk_i); #1;
                m_rdy = 1;
            end
            drive(rand_instr(), $urandom, $urandom, $urandom);
            in_valid_i  = ($urandom_range(0, 3) != 0);
            out_ready_i = ($urandom_range(0, 2) != 0);
            flush_i     = ($urandom_range(0, 19) == 0);
            step();
        end
        in_valid_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b1;
        for (int n = 0; n < 4; n++) step();
        chk("final_empty", out_valid_o, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rv_alu_issue.md
Name: rv_alu_issue

Overview:
ALU issue stage: the producer side of the ALU operand interface.
- Accepts a decoded-stage instruction word, PC and register-file read data through a valid/ready handshake.
- Decodes RV32I integer ops into operand A, operand B and a one-hot op select.
- Presents them from registered outputs through a valid/ready handshake to the execute stage, which feeds the combinational ALU.
- Sits between register read and execute.

Parameters:
XLEN, 32, datapath width; only 32 supported.
OPSEL_W, 10, op select width; one-hot.

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
flush_i  input  1  drop all held and incoming instructions
in_valid_i  input  1  instruction/operands valid
in_ready_o  output  1  stage can accept
instr_i  input  32  instruction word
pc_i  input  32  instruction PC
rs1_data_i  input  32  rs1 read data
rs2_data_i  input  32  rs2 read data
out_valid_o  output  1  issued entry valid
out_ready_i  input  1  execute accepts
opr_a_o  output  32  ALU operand A
opr_b_o  output  32  ALU operand B
op_sel_o  output  10  one-hot op: b0 ADD, b1 SUB, b2 SLL, b3 SRL, b4 SRA, b5 OR, b6 AND, b7 XOR, b8 SLTU, b9 SLT
illegal_o  output  1  entry is unsupported/illegal
issue_cnt_o  output  32  count of accepted output transfers

Behaviour:
- Reset is asynchronous, active-low: clk_i, rst_ni. While rst_ni=0 all outputs are 0, including out_valid_o, op_sel_o and issue_cnt_o. in_ready_o is 1 one cycle after deassertion.
- Input handshake: transfer when in_valid_i && in_ready_o. Output handshake: transfer when out_valid_o && out_ready_i.
- Held outputs stay stable while out_valid_o && !out_ready_i.
- Latency: 1 cycle. Data accepted at edge N is visible on the outputs after edge N.
- Base mode uses a single output register. in_ready_o = !out_valid_o || out_ready_i. Full throughput when out_ready_i=1.
- Decode by opcode instr[6:0]:
  - OP 0110011: a=rs1, b=rs2. funct3/funct7 select ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND. funct7 must be 0000000, or 0100000 only with f3=000 or 101; else illegal.
  - OP-IMM 0010011: a=rs1, b=sign-extended I-imm. SLLI requires funct7=0000000. SRLI/SRAI select on funct7 0000000/0100000. Shifts use b={27'h0,instr[24:20]}. Any other funct7 is illegal.
  - LOAD 0000011 and STORE 0100011: ADD, a=rs1, b=sign-extended I-imm or S-imm respectively.
  - LUI 0110111: ADD, a=0, b={instr[31:12],12'h0}.
  - AUIPC 0010111: ADD, a=pc, b=U-imm.
  - JAL 1101111 and JALR 1100111: ADD, a=pc, b=4 (link value).
  - All other opcodes, including BRANCH, SYSTEM, FENCE and funct3 violations: illegal_o=1, op_sel=0, a=b=0. Illegal entries still flow through the handshake.
- Exactly one op_sel bit is set for legal entries; zero bits are set for illegal entries.
- issue_cnt_o increments by 1 on every output transfer and wraps 0xFFFFFFFF to 0. It does not increment on flush.
- flush_i:
  - All valid entries are cleared at the next edge.
  - An input presented in the same cycle is discarded.
  - A simultaneous output transfer still counts.
  - in_ready_o is unaffected.
- rst_ni assertion mid-transfer drops all entries immediately.

Optional Feature:
RV_ISSUE_SKID_EN.
- Defined: a 2-entry skid buffer is added. in_ready_o becomes a pure register output, set when at least one entry is free, with no combinational path from out_ready_i. Full throughput is maintained. Ordering is FIFO. Flush clears both entries.
- Undefined: single register with a combinational ready path, as described in Behaviour.

Test Plan:
- ADD x3,x1,x2 (instr 0x002081B3), rs1=5, rs2=7 -> next cycle opr_a=5, opr_b=7, op_sel=10'h001, illegal=0.
- ADDI x1,x0,-1 (0xFFF00093), rs1=0 -> opr_b=0xFFFFFFFF, op_sel=10'h001. SUB x0,x1,x2 (0x40208033) -> op_sel=10'h002.
- SRAI x1,x1,3 (0x4030D093) -> op_sel=10'h010, opr_b=3. LUI x1,0x12345 (0x123450B7) -> opr_a=0, opr_b=0x12345000.
- BEQ (0x00208063) and instr 0xFE20D0B3 (bad funct7) -> illegal_o=1, op_sel=0.
- Backpressure: out_ready_i=0 for 3 cycles with 3 queued inputs -> outputs stable; no loss or duplication; order preserved; issue_cnt_o=3 after drain. Repeat with RV_ISSUE_SKID_EN and check in_ready_o depends only on state.
- flush_i with an entry held plus a new input -> out_valid_o=0 next cycle, issue_cnt_o unchanged. Async rst_ni pulse mid-stream -> all outputs 0 immediately.
